// File: rtl/simple_pc_pkg.sv
// Shared definitions for the simple PC sequencer: next-PC operation codes and
// the phase value on which the PC may be updated.
package simple_pc_pkg;

    typedef enum logic [2:0] {
        PC_OP_REL  = 3'd0,
        PC_OP_ABS  = 3'd1,
        PC_OP_CALL = 3'd2,
        PC_OP_RET  = 3'd3,
        PC_OP_HOLD = 3'd4
    } pc_op_e;

    localparam logic [1:0] PHASE_UPD = 2'b11;

endpackage

// File: rtl/simple_pc_ras.sv
// Return-address stack: circular LIFO buffer. A push when full overwrites the
// oldest entry and leaves the count saturated at DEPTH.
module simple_pc_ras #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             top,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] ptr_reg;      // next free slot; top of stack sits just below
    logic [CW-1:0] count_reg;

    assign full  = (count_reg == CW'(DEPTH));
    assign empty = (count_reg == '0);
    assign count = count_reg;
    assign top   = mem[ptr_reg - AW'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_reg   <= '0;
            count_reg <= '0;
        end else if (push) begin
            ptr_reg <= ptr_reg + AW'(1);
            if (!full) begin
                count_reg <= count_reg + CW'(1);
            end
        end else if (pop && !empty) begin
            ptr_reg   <= ptr_reg - AW'(1);
            count_reg <= count_reg - CW'(1);
        end
    end

endmodule

// File: rtl/simple_pc_seq.sv
// Program-counter sequencer with relative/absolute jumps and call/return.
// Define SIMPLE_PC_SEQ_RAS_EN to include the return-address stack.
module simple_pc_seq
    import simple_pc_pkg::*;
#(
    parameter int unsigned     PC_W      = 8,
    parameter int unsigned     OFS_W     = 8,
    parameter int unsigned     RAS_DEPTH = 4,
    parameter logic [PC_W-1:0] RESET_PC  = '0
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic [1:0]                   phase,
    input  logic                         stall,
    input  logic [2:0]                   op,
    input  logic signed [OFS_W-1:0]      ofs,
    input  logic [PC_W-1:0]              tgt,
    input  logic                         clr_err,
    output logic [PC_W-1:0]              pc,
    output logic                         upd,
    output logic [$clog2(RAS_DEPTH):0]   ras_cnt,
    output logic                         ras_ovf,
    output logic                         ras_unf
);

    logic [PC_W-1:0] pc_reg, pc_next;
    logic            upd_reg, upd_next;
    logic [PC_W-1:0] ofs_ext, pc_inc;
    logic            upd_cycle;

    // Sized cast of a signed operand sign-extends the offset to PC width.
    assign ofs_ext   = PC_W'(ofs);
    assign pc_inc    = pc_reg + PC_W'(1);
    assign upd_cycle = (phase == PHASE_UPD) && !stall;

`ifdef SIMPLE_PC_SEQ_RAS_EN
    logic                          push, pop, ras_full, ras_empty;
    logic [PC_W-1:0]               ras_top;
    logic                          ovf_reg, unf_reg, set_ovf, set_unf;

    simple_pc_ras #(
        .DEPTH (RAS_DEPTH),
        .W     (PC_W)
    ) u_ras (
        .clk    (clk),
        .resetn (resetn),
        .push   (push),
        .pop    (pop),
        .din    (pc_inc),
        .top    (ras_top),
        .count  (ras_cnt),
        .full   (ras_full),
        .empty  (ras_empty)
    );

    // Sticky flags: a new error in the clearing cycle keeps the flag set.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ovf_reg <= 1'b0;
            unf_reg <= 1'b0;
        end else begin
            ovf_reg <= (ovf_reg & ~clr_err) | set_ovf;
            unf_reg <= (unf_reg & ~clr_err) | set_unf;
        end
    end

    assign ras_ovf = ovf_reg;
    assign ras_unf = unf_reg;
`else
    logic unused_clr_err;
    assign unused_clr_err = clr_err;
    assign ras_cnt        = '0;
    assign ras_ovf        = 1'b0;
    assign ras_unf        = 1'b0;
`endif

    always_comb begin
        pc_next  = pc_reg;
        upd_next = 1'b0;
`ifdef SIMPLE_PC_SEQ_RAS_EN
        push     = 1'b0;
        pop      = 1'b0;
        set_ovf  = 1'b0;
        set_unf  = 1'b0;
`endif
        if (upd_cycle) begin
            case (op)
                PC_OP_REL: begin
                    pc_next  = pc_reg + ofs_ext;
                    upd_next = 1'b1;
                end
                PC_OP_ABS: begin
                    pc_next  = tgt;
                    upd_next = 1'b1;
                end
                PC_OP_CALL: begin
                    pc_next  = tgt;
                    upd_next = 1'b1;
`ifdef SIMPLE_PC_SEQ_RAS_EN
                    push     = 1'b1;
                    set_ovf  = ras_full;
`endif
                end
                PC_OP_RET: begin
                    upd_next = 1'b1;
`ifdef SIMPLE_PC_SEQ_RAS_EN
                    if (ras_empty) begin
                        pc_next = pc_inc;
                        set_unf = 1'b1;
                    end else begin
                        pc_next = ras_top;
                        pop     = 1'b1;
                    end
`else
                    pc_next  = pc_inc;
`endif
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_reg  <= RESET_PC;
            upd_reg <= 1'b0;
        end else begin
            pc_reg  <= pc_next;
            upd_reg <= upd_next;
        end
    end

    assign pc  = pc_reg;
    assign upd = upd_reg;

endmodule

// File: tb/tb_simple_pc_seq.sv
// Directed self-checking bench for simple_pc_seq; expectations follow the
// stack configuration selected by SIMPLE_PC_SEQ_RAS_EN.
module tb_simple_pc_seq;

`ifdef SIMPLE_PC_SEQ_RAS_EN
    localparam bit RAS_EN = 1'b1;
`else
    localparam bit RAS_EN = 1'b0;
`endif

    localparam logic [2:0] OP_REL  = 3'd0;
    localparam logic [2:0] OP_ABS  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_RET  = 3'd3;
    localparam logic [2:0] OP_HOLD = 3'd4;

    logic       clk = 1'b0;
    logic       resetn;
    logic [1:0] phase;
    logic       stall;
    logic [2:0] op;
    logic [7:0] ofs;
    logic [7:0] tgt;
    logic       clr_err;
    logic [7:0] pc;
    logic       upd;
    logic [2:0] ras_cnt;
    logic       ras_ovf;
    logic       ras_unf;

    int checks   = 0;
    int failures = 0;

    simple_pc_seq #(
        .PC_W      (8),
        .OFS_W     (8),
        .RAS_DEPTH (4),
        .RESET_PC  (8'h05)
    ) dut (
        .clk     (clk),
        .resetn  (resetn),
        .phase   (phase),
        .stall   (stall),
        .op      (op),
        .ofs     (ofs),
        .tgt     (tgt),
        .clr_err (clr_err),
        .pc      (pc),
        .upd     (upd),
        .ras_cnt (ras_cnt),
        .ras_ovf (ras_ovf),
        .ras_unf (ras_unf)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        phase   = 2'd0;
        stall   = 1'b0;
        op      = OP_HOLD;
        clr_err = 1'b0;
    endtask

    // One update cycle, then back to idle; outputs are sampled 1 ns after the edge.
    task automatic do_op(input logic [2:0] o, input logic [7:0] of, input logic [7:0] t);
        phase = 2'd3;
        stall = 1'b0;
        op    = o;
        ofs   = of;
        tgt   = t;
        tick();
        idle();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        idle();
        ofs = 8'h00;
        tgt = 8'h00;
        tick();
        tick();
        checks++; if (pc !== 8'h05) begin failures++; $display("FAIL reset_pc got=%h exp=05", pc); end
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL reset_upd got=%b exp=0", upd); end
        checks++; if (ras_cnt !== 3'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", ras_cnt); end
        checks++; if ({ras_ovf, ras_unf} !== 2'b00) begin failures++; $display("FAIL reset_flags got=%b%b exp=00", ras_ovf, ras_unf); end
        resetn = 1'b1;
        tick();
        $display("reset: pc=%h upd=%b cnt=%0d", pc, upd, ras_cnt);
    endtask

    task automatic test_rel_wrap();
        do_op(OP_ABS, 8'h00, 8'hFE);
        do_op(OP_REL, 8'h03, 8'h00);
        checks++; if (pc !== 8'h01) begin failures++; $display("FAIL rel_plus3_pc got=%h exp=01", pc); end
        checks++; if (upd !== 1'b1) begin failures++; $display("FAIL rel_plus3_upd got=%b exp=1", upd); end
        tick();
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL rel_upd_pulse got=%b exp=0", upd); end
        do_op(OP_REL, 8'hFE, 8'h00);
        checks++; if (pc !== 8'hFF) begin failures++; $display("FAIL rel_minus2_pc got=%h exp=ff", pc); end
        do_op(OP_REL, 8'h00, 8'h00);
        checks++; if ({pc, upd} !== {8'hFF, 1'b1}) begin failures++; $display("FAIL rel_zero got pc=%h upd=%b exp pc=ff upd=1", pc, upd); end
        do_op(OP_REL, 8'h80, 8'h00);
        checks++; if (pc !== 8'h7F) begin failures++; $display("FAIL rel_minus128_pc got=%h exp=7f", pc); end
        do_op(OP_ABS, 8'h00, 8'hFF);
        $display("rel_wrap: pc=%h", pc);
    endtask

    task automatic test_gating();
        op  = OP_ABS;
        tgt = 8'h40;
        for (int p = 0; p < 3; p++) begin
            phase = p[1:0];
            stall = 1'b0;
            tick();
            checks++; if ({pc, upd} !== {8'hFF, 1'b0}) begin failures++; $display("FAIL gate_phase%0d got pc=%h upd=%b exp pc=ff upd=0", p, pc, upd); end
        end
        phase = 2'd3;
        stall = 1'b1;
        tick();
        checks++; if ({pc, upd} !== {8'hFF, 1'b0}) begin failures++; $display("FAIL gate_stall got pc=%h upd=%b exp pc=ff upd=0", pc, upd); end
        stall = 1'b0;
        tick();
        idle();
        checks++; if ({pc, upd} !== {8'h40, 1'b1}) begin failures++; $display("FAIL gate_open got pc=%h upd=%b exp pc=40 upd=1", pc, upd); end
        do_op(OP_HOLD, 8'h01, 8'h99);
        checks++; if ({pc, upd} !== {8'h40, 1'b0}) begin failures++; $display("FAIL hold_op4 got pc=%h upd=%b exp pc=40 upd=0", pc, upd); end
        do_op(3'd7, 8'h01, 8'h99);
        checks++; if ({pc, upd} !== {8'h40, 1'b0}) begin failures++; $display("FAIL hold_op7 got pc=%h upd=%b exp pc=40 upd=0", pc, upd); end
        $display("gating: pc=%h", pc);
    endtask

    task automatic test_call_ret();
        logic [7:0] exp_ret;
        exp_ret = RAS_EN ? 8'h11 : 8'h81;
        do_op(OP_ABS, 8'h00, 8'h10);
        do_op(OP_CALL, 8'h00, 8'h80);
        checks++; if ({pc, upd} !== {8'h80, 1'b1}) begin failures++; $display("FAIL call_pc got pc=%h upd=%b exp pc=80 upd=1", pc, upd); end
        checks++; if (ras_cnt !== (RAS_EN ? 3'd1 : 3'd0)) begin failures++; $display("FAIL call_cnt got=%0d exp=%0d", ras_cnt, RAS_EN ? 1 : 0); end
        do_op(OP_RET, 8'h00, 8'h00);
        checks++; if ({pc, upd} !== {exp_ret, 1'b1}) begin failures++; $display("FAIL ret_pc got pc=%h upd=%b exp pc=%h upd=1", pc, upd, exp_ret); end
        checks++; if ({ras_cnt, ras_unf} !== 4'd0) begin failures++; $display("FAIL ret_cnt got cnt=%0d unf=%b exp cnt=0 unf=0", ras_cnt, ras_unf); end
        $display("call_ret: pc=%h cnt=%0d", pc, ras_cnt);
    endtask

    task automatic test_overflow();
        logic [7:0] exp_pc [4];
        logic [7:0] base;
        if (RAS_EN) begin
            exp_pc[0] = 8'h81; exp_pc[1] = 8'h61; exp_pc[2] = 8'h41; exp_pc[3] = 8'h21;
        end else begin
            exp_pc[0] = 8'hA1; exp_pc[1] = 8'hA2; exp_pc[2] = 8'hA3; exp_pc[3] = 8'hA4;
        end
        for (int i = 0; i < 5; i++) begin
            base = 8'(i * 32);
            do_op(OP_ABS, 8'h00, base);
            do_op(OP_CALL, 8'h00, base + 8'h20);
        end
        checks++; if (ras_ovf !== RAS_EN) begin failures++; $display("FAIL ovf_flag got=%b exp=%b", ras_ovf, RAS_EN); end
        checks++; if (ras_cnt !== (RAS_EN ? 3'd4 : 3'd0)) begin failures++; $display("FAIL ovf_cnt got=%0d exp=%0d", ras_cnt, RAS_EN ? 4 : 0); end
        for (int i = 0; i < 4; i++) begin
            do_op(OP_RET, 8'h00, 8'h00);
            checks++; if (pc !== exp_pc[i]) begin failures++; $display("FAIL ovf_ret%0d got=%h exp=%h", i, pc, exp_pc[i]); end
        end
        checks++; if ({ras_cnt, ras_unf} !== 4'd0) begin failures++; $display("FAIL ovf_drain got cnt=%0d unf=%b exp cnt=0 unf=0", ras_cnt, ras_unf); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if ({ras_ovf, upd} !== 2'b00) begin failures++; $display("FAIL ovf_clear got ovf=%b upd=%b exp ovf=0 upd=0", ras_ovf, upd); end
        $display("overflow: pc=%h cnt=%0d ovf=%b", pc, ras_cnt, ras_ovf);
    endtask

    task automatic test_underflow();
        do_op(OP_ABS, 8'h00, 8'h33);
        do_op(OP_RET, 8'h00, 8'h00);
        checks++; if ({pc, upd} !== {8'h34, 1'b1}) begin failures++; $display("FAIL unf_pc got pc=%h upd=%b exp pc=34 upd=1", pc, upd); end
        checks++; if ({ras_unf, ras_cnt} !== {RAS_EN, 3'd0}) begin failures++; $display("FAIL unf_flag got unf=%b cnt=%0d exp unf=%b cnt=0", ras_unf, ras_cnt, RAS_EN); end
        tick();
        checks++; if (ras_unf !== RAS_EN) begin failures++; $display("FAIL unf_sticky got=%b exp=%b", ras_unf, RAS_EN); end
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        checks++; if (ras_unf !== 1'b0) begin failures++; $display("FAIL unf_clear got=%b exp=0", ras_unf); end
        clr_err = 1'b1;
        do_op(OP_RET, 8'h00, 8'h00);
        checks++; if ({pc, ras_unf} !== {8'h35, RAS_EN}) begin failures++; $display("FAIL unf_set_wins got pc=%h unf=%b exp pc=35 unf=%b", pc, ras_unf, RAS_EN); end
        $display("underflow: pc=%h unf=%b", pc, ras_unf);
    endtask

    task automatic test_reset_mid();
        do_op(OP_ABS, 8'h00, 8'h50);
        do_op(OP_CALL, 8'h00, 8'h70);
        resetn = 1'b0;
        do_op(OP_CALL, 8'h00, 8'h90);
        checks++; if ({pc, upd} !== {8'h05, 1'b0}) begin failures++; $display("FAIL rstmid_pc got pc=%h upd=%b exp pc=05 upd=0", pc, upd); end
        checks++; if ({ras_cnt, ras_ovf, ras_unf} !== 5'd0) begin failures++; $display("FAIL rstmid_ras got cnt=%0d ovf=%b unf=%b exp 0 0 0", ras_cnt, ras_ovf, ras_unf); end
        resetn = 1'b1;
        do_op(OP_REL, 8'h01, 8'h00);
        checks++; if ({pc, upd} !== {8'h06, 1'b1}) begin failures++; $display("FAIL rstmid_first got pc=%h upd=%b exp pc=06 upd=1", pc, upd); end
        do_op(OP_RET, 8'h00, 8'h00);
        checks++; if ({pc, ras_unf} !== {8'h07, RAS_EN}) begin failures++; $display("FAIL rstmid_empty_ret got pc=%h unf=%b exp pc=07 unf=%b", pc, ras_unf, RAS_EN); end
        $display("reset_mid: pc=%h", pc);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_ret;
        exp_ret = RAS_EN ? 8'h0C : 8'hC1;
        phase = 2'd3;
        op    = OP_REL;
        ofs   = 8'h02;
        tick();
        checks++; if ({pc, upd} !== {8'h09, 1'b1}) begin failures++; $display("FAIL b2b_rel1 got pc=%h upd=%b exp pc=09 upd=1", pc, upd); end
        tick();
        checks++; if ({pc, upd} !== {8'h0B, 1'b1}) begin failures++; $display("FAIL b2b_rel2 got pc=%h upd=%b exp pc=0b upd=1", pc, upd); end
        op  = OP_CALL;
        tgt = 8'hC0;
        tick();
        checks++; if (pc !== 8'hC0) begin failures++; $display("FAIL b2b_call got=%h exp=c0", pc); end
        op = OP_RET;
        tick();
        idle();
        checks++; if ({pc, upd, ras_cnt} !== {exp_ret, 1'b1, 3'd0}) begin failures++; $display("FAIL b2b_ret got pc=%h upd=%b cnt=%0d exp pc=%h upd=1 cnt=0", pc, upd, ras_cnt, exp_ret); end
        tick();
        checks++; if (upd !== 1'b0) begin failures++; $display("FAIL b2b_idle_upd got=%b exp=0", upd); end
        $display("back_to_back: pc=%h", pc);
    endtask

    initial begin
        test_reset();
        test_rel_wrap();
        test_gating();
        test_call_ret();
        test_overflow();
        test_underflow();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
